// File: rtl/risc16_pkg.sv
// Shared types for the risc16 core pipeline: EX->MEM task, MEM->WB task and
// the MEM stage state encoding.
package risc16_pkg;

    localparam int XLEN    = 16;
    localparam int REG_A_W = 3;

    typedef struct packed {
        logic               valid;
        logic               mem_rd;
        logic               mem_wr;
        logic               wb_en;
        logic [REG_A_W-1:0] wb_addr;
        logic [XLEN-1:0]    st_data;
    } id_res_t;

    typedef struct packed {
        id_res_t         id_res;
        logic [XLEN-1:0] alu_res;
    } mem_task_t;

    typedef struct packed {
        logic               valid;
        logic               wb_en;
        logic [REG_A_W-1:0] wb_addr;
        logic [XLEN-1:0]    wb_data;
    } wb_task_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    function automatic wb_task_t make_wb(input logic               wb_en,
                                         input logic [REG_A_W-1:0] wb_addr,
                                         input logic [XLEN-1:0]    wb_data);
        wb_task_t t;
        t.valid   = 1'b1;
        t.wb_en   = wb_en;
        t.wb_addr = wb_addr;
        t.wb_data = wb_data;
        return t;
    endfunction

endpackage

// File: rtl/stage_mem.sv
// MEM stage of the risc16 core: issues LW/SW on a word-addressed data bus with
// arbitrary wait states, stalls EX while busy, and forwards results to WB.
module stage_mem
    import risc16_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  mem_task_t         task_i,
    output logic              stall_o,
    output wb_task_t          wb_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic              bus_err_o
);

    localparam int           CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic         TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t          state_r;
    mem_state_t          state_n_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [XLEN-1:0]     wdata_r;
    logic [XLEN-1:0]     alu_r;
    logic                we_r;
    logic                wb_en_r;
    logic [REG_A_W-1:0]  wb_addr_r;
    logic [CNT_W-1:0]    tmo_cnt_r;
    logic                req_r;
    logic                bus_err_r;
    wb_task_t            wb_r;
    wb_task_t            wb_n_s;
    logic                stall_s;
    logic                capture_s;
    logic                err_set_s;
    logic                mem_op_s;
    logic                tmo_hit_s;
    logic                access_s;

    assign mem_op_s  = task_i.id_res.mem_rd | task_i.id_res.mem_wr;
    assign access_s  = (state_r == ACCESS);
    assign tmo_hit_s = TMO_EN & access_s & (tmo_cnt_r == TMO_LIMIT);

    // Next-state, stall and next write-back task; ack takes priority over timeout.
    always_comb begin
        state_n_s = state_r;
        stall_s   = 1'b0;
        capture_s = 1'b0;
        err_set_s = 1'b0;
        wb_n_s    = '0;
        case (state_r)
            IDLE: begin
                if (task_i.id_res.valid && mem_op_s) begin
                    stall_s   = 1'b1;
                    capture_s = 1'b1;
                    state_n_s = ACCESS;
                end else if (task_i.id_res.valid) begin
                    wb_n_s = make_wb(task_i.id_res.wb_en, task_i.id_res.wb_addr, task_i.alu_res);
                end else begin
                    wb_n_s = '0;
                end
            end
            ACCESS: begin
                if (dmem_ack_i) begin
                    state_n_s = IDLE;
                    wb_n_s    = make_wb(wb_en_r, wb_addr_r, we_r ? alu_r : dmem_rdata_i);
                end else if (tmo_hit_s) begin
                    state_n_s = IDLE;
                    err_set_s = 1'b1;
                    wb_n_s    = make_wb(1'b0, wb_addr_r, 16'h0000);
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State, request, error flag and write-back output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            req_r     <= 1'b0;
            bus_err_r <= 1'b0;
            wb_r      <= '0;
        end else begin
            state_r <= state_n_s;
            wb_r    <= wb_n_s;
            if (capture_s) begin
                req_r <= 1'b1;
            end else if (access_s && (dmem_ack_i || tmo_hit_s)) begin
                req_r <= 1'b0;
            end
            if (err_set_s) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    // Access capture registers: held stable on the bus for the whole access.
    // A store never writes the register file, so its wb_en is cleared here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_r    <= '0;
            wdata_r   <= 16'h0000;
            alu_r     <= 16'h0000;
            we_r      <= 1'b0;
            wb_en_r   <= 1'b0;
            wb_addr_r <= 3'd0;
        end else if (capture_s) begin
            addr_r    <= ADDR_W'(task_i.alu_res);
            wdata_r   <= task_i.id_res.st_data;
            alu_r     <= task_i.alu_res;
            we_r      <= task_i.id_res.mem_wr;
            wb_en_r   <= task_i.id_res.wb_en & ~task_i.id_res.mem_wr;
            wb_addr_r <= task_i.id_res.wb_addr;
        end
    end

    // Wait-state counter: zeroed on entry to ACCESS, counts cycles without ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_r <= '0;
        end else if (capture_s) begin
            tmo_cnt_r <= '0;
        end else if (access_s && !dmem_ack_i) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end
    end

    assign stall_o      = stall_s;
    assign wb_o         = wb_r;
    assign dmem_req_o   = req_r;
    assign dmem_we_o    = we_r;
    assign dmem_addr_o  = addr_r;
    assign dmem_wdata_o = wdata_r;
    assign bus_err_o    = bus_err_r;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: randomized LW/SW/ALU tasks, a bus responder
// with planned wait states, and directed timeout / reset / back-to-back cases.
module tb_stage_mem;
    import risc16_pkg::*;

    localparam int TMO   = 8;
    localparam int NEVER = 1000;

    logic        clk;
    logic        rst_i;
    mem_task_t   task_i;
    logic        stall_o;
    wb_task_t    wb_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [15:0] dmem_wdata_o;
    logic [15:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        bus_err_o;
    logic        resp_ack;
    logic        force_ack;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          waits;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    wb_task_t    wb_q[$];
    int          wb_times[$];
    logic [15:0] ref_mem [0:255];
    logic [15:0] phys_mem[0:255];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    assign dmem_ack_i = resp_ack | force_ack;

    stage_mem #(.ADDR_W(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .task_i       (task_i),
        .stall_o      (stall_o),
        .wb_o         (wb_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i),
        .bus_err_o    (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_test();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Monitor: every valid write-back must match the oldest expectation.
    initial begin
        wb_task_t exp;
        forever begin
            @(negedge clk);
            if (!rst_i && wb_o.valid) begin
                wb_times.push_back(cyc);
                if (wb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got=%h want=none", wb_o);
                end else begin
                    exp = wb_q.pop_front();
                    chk("wb_task", 32'(wb_o), 32'(exp));
                end
            end
        end
    end

    // Bus responder: checks each request against the plan and acks after the planned waits.
    initial begin
        bus_exp_t cur;
        bit       active;
        bit       ack_was;
        int       req_cycles;
        active       = 1'b0;
        req_cycles   = 0;
        resp_ack     = 1'b0;
        dmem_rdata_i = 16'h0000;
        forever begin
            @(negedge clk);
            ack_was  = resp_ack;
            resp_ack = 1'b0;
            if (rst_i) begin
                active = 1'b0;
            end else begin
                if (ack_was) chk("req_drop_after_ack", 32'(dmem_req_o), 32'd0);
                if (active && !dmem_req_o) begin
                    if (cur.waits == NEVER) begin
                        chk("timeout_req_cycles", 32'(req_cycles), 32'(TMO));
                    end else begin
                        chk("req_dropped_early", 32'(req_cycles), 32'(cur.waits + 1));
                    end
                    active = 1'b0;
                end
                if (dmem_req_o && !active && !ack_was) begin
                    if (bus_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL bus_unexpected: got=req addr %h want=none", dmem_addr_o);
                    end else begin
                        cur        = bus_q.pop_front();
                        active     = 1'b1;
                        req_cycles = 0;
                    end
                end
                if (active && dmem_req_o) begin
                    req_cycles++;
                    chk("bus_we", 32'(dmem_we_o), 32'(cur.we));
                    chk("bus_addr", 32'(dmem_addr_o), 32'(cur.addr));
                    if (cur.we) chk("bus_wdata", 32'(dmem_wdata_o), 32'(cur.wdata));
                    if (cur.waits != NEVER && req_cycles == cur.waits + 1) begin
                        resp_ack = 1'b1;
                        if (cur.we) phys_mem[cur.addr[7:0]] = cur.wdata;
                        else        dmem_rdata_i = phys_mem[cur.addr[7:0]];
                        active = 1'b0;
                    end
                end
            end
        end
    end

    // Issue one task, record expectations, and hold it until EX may advance.
    task automatic issue(input logic rd, input logic wr, input logic wb_en, input logic [2:0] wa,
                         input logic [15:0] st, input logic [15:0] alu, input int waits);
        bus_exp_t b;
        wb_task_t exp;
        int       exp_stall;
        int       n_stall;
        int       n;
        if (!rd && !wr) begin
            exp       = make_wb(wb_en, wa, alu);
            exp_stall = 0;
        end else begin
            b.we = wr; b.addr = alu; b.wdata = st; b.waits = waits;
            bus_q.push_back(b);
            if (waits == NEVER) begin
                exp       = make_wb(1'b0, wa, 16'h0000);
                exp_stall = TMO;
            end else begin
                exp_stall = waits + 1;
                if (wr) begin
                    ref_mem[alu[7:0]] = st;
                    exp = make_wb(1'b0, wa, alu);
                end else begin
                    exp = make_wb(wb_en, wa, ref_mem[alu[7:0]]);
                end
            end
        end
        wb_q.push_back(exp);
        task_i.id_res.valid   = 1'b1;
        task_i.id_res.mem_rd  = rd;
        task_i.id_res.mem_wr  = wr;
        task_i.id_res.wb_en   = wb_en;
        task_i.id_res.wb_addr = wa;
        task_i.id_res.st_data = st;
        task_i.alu_res        = alu;
        n_stall = 0;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL stall_wait: got=stall stuck want=release within 200 cycles");
                finish_test();
            end
            if (!stall_o) break;
            n_stall++;
        end
        chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
        @(posedge clk);
        #1;
        task_i = '0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Main stimulus sequence.
    initial begin
        int kind;
        logic [15:0] v;
        task_i    = '0;
        force_ack = 1'b0;
        rst_i     = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = 16'(i * 257) ^ 16'h5A00;
            ref_mem[i]  = v;
            phys_mem[i] = v;
        end
        ref_mem[8'h40]  = 16'hBEEF;
        phys_mem[8'h40] = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb", 32'(wb_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_addr", 32'(dmem_addr_o), 32'd0);
        chk("rst_wdata", 32'(dmem_wdata_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        rst_i = 1'b0;
        idle_cycles(2);

        issue(1'b0, 1'b0, 1'b1, 3'd3, 16'h0000, 16'h1234, 0);
        chk("alu_no_req", 32'(dmem_req_o), 32'd0);
        issue(1'b1, 1'b0, 1'b1, 3'd5, 16'h0000, 16'h0040, 2);
        idle_cycles(1);
        issue(1'b0, 1'b1, 1'b1, 3'd2, 16'hA5A5, 16'h0010, 0);
        issue(1'b1, 1'b1, 1'b1, 3'd6, 16'h3C3C, 16'h0011, 1);
        issue(1'b1, 1'b0, 1'b1, 3'd1, 16'h0000, 16'h0010, 0);
        idle_cycles(2);

        issue(1'b1, 1'b0, 1'b1, 3'd4, 16'h0000, 16'h0020, 1);
        issue(1'b1, 1'b0, 1'b1, 3'd7, 16'h0000, 16'h0021, 1);
        idle_cycles(3);
        chk("b2b_spacing", 32'(wb_times[wb_times.size()-1] - wb_times[wb_times.size()-2]), 32'd3);

        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0)
                issue(1'b0, 1'b0, 1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 0);
            else
                issue(kind == 1, kind == 2, 1'($urandom), 3'($urandom), 16'($urandom),
                      16'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end
        idle_cycles(2);
        chk("err_before_timeout", 32'(bus_err_o), 32'd0);

        issue(1'b1, 1'b0, 1'b1, 3'd5, 16'h0000, 16'h0033, NEVER);
        issue(1'b0, 1'b0, 1'b1, 3'd2, 16'h0000, 16'h7777, 0);
        idle_cycles(1);
        chk("err_after_timeout", 32'(bus_err_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, 1'b0, 1'b1, 3'($urandom), 16'h0000, 16'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3)));
        end
        idle_cycles(1);
        chk("err_sticky", 32'(bus_err_o), 32'd1);

        bus_q.push_back('{we: 1'b0, addr: 16'h0050, wdata: 16'h0000, waits: NEVER});
        task_i.id_res.valid   = 1'b1;
        task_i.id_res.mem_rd  = 1'b1;
        task_i.id_res.wb_en   = 1'b1;
        task_i.id_res.wb_addr = 3'd4;
        task_i.alu_res        = 16'h0050;
        idle_cycles(2);
        chk("mid_access_req", 32'(dmem_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rst_req_drop", 32'(dmem_req_o), 32'd0);
        chk("rst_wb_clear", 32'(wb_o), 32'd0);
        chk("rst_err_clear", 32'(bus_err_o), 32'd0);
        task_i = '0;
        idle_cycles(2);
        rst_i = 1'b0;
        idle_cycles(1);
        force_ack = 1'b1;
        idle_cycles(1);
        force_ack = 1'b0;
        chk("late_ack_req", 32'(dmem_req_o), 32'd0);
        chk("late_ack_wb", 32'(wb_o.valid), 32'd0);
        issue(1'b1, 1'b0, 1'b1, 3'd3, 16'h0000, 16'h0040, 0);
        idle_cycles(3);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        finish_test();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
